// File: rtl/wb_master_port.sv
// Wishbone classic-cycle initiator: turns single-beat core requests into bus cycles,
// with bounded retry on rty and a watchdog that aborts a cycle nobody terminates.
module wb_master_port #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4,
    parameter int TGA_WIDTH  = 1,
    parameter int TGC_WIDTH  = 1,
    parameter int TGDO_WIDTH = 1,
    parameter int TGDI_WIDTH = 1,
    parameter int MAX_RETRY  = 3,
    parameter int RETRY_GAP  = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_adr_i,
    input  logic [DATA_WIDTH-1:0] req_dat_i,
    input  logic [SEL_WIDTH-1:0]  req_sel_i,
    input  logic                  req_lock_i,
    input  logic [TGA_WIDTH-1:0]  req_tga_i,
    input  logic [TGC_WIDTH-1:0]  req_tgc_i,
    input  logic [TGDO_WIDTH-1:0] req_tgd_i,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] resp_dat_o,
    output logic [TGDI_WIDTH-1:0] resp_tgd_o,
    output logic                  resp_err_o,
    output logic [1:0]            resp_code_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic                  we_o,
    output logic [SEL_WIDTH-1:0]  sel_o,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  lock_o,
    input  logic                  ack_i,
    input  logic                  err_i,
    input  logic                  rty_i,
    output logic [TGA_WIDTH-1:0]  tga_o,
    output logic [TGC_WIDTH-1:0]  tgc_o,
    output logic [TGDO_WIDTH-1:0] tgd_o,
    input  logic [TGDI_WIDTH-1:0] tgd_i
);

    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(RETRY_GAP + 1);
    localparam logic [RW-1:0] RETRY_MAX_C = RW'(MAX_RETRY);
    localparam logic [TW-1:0] TMO_LAST_C  = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST_C  = GW'(RETRY_GAP - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_GAP, ST_RESP} state_e;

    state_e                  state_q, state_d;
    logic                    req_ready_q, req_ready_d;
    logic                    cyc_q, cyc_d;
    logic                    stb_q, stb_d;
    logic                    lock_q, lock_d;
    logic                    lock_req_q, lock_req_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic [SEL_WIDTH-1:0]    sel_q, sel_d;
    logic [TGA_WIDTH-1:0]    tga_q, tga_d;
    logic [TGC_WIDTH-1:0]    tgc_q, tgc_d;
    logic [TGDO_WIDTH-1:0]   tgd_q, tgd_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_dat_q, resp_dat_d;
    logic [TGDI_WIDTH-1:0]   resp_tgd_q, resp_tgd_d;
    logic                    resp_err_q, resp_err_d;
    logic [1:0]              resp_code_q, resp_code_d;
    logic [RW-1:0]           retry_q, retry_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic [GW-1:0]           gap_q, gap_d;
    logic                    done_s;
    logic [1:0]              code_s;

    // Next-state and next-output computation for the transaction sequencer.
    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        lock_d       = lock_q;
        lock_req_d   = lock_req_q;
        we_d         = we_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        sel_d        = sel_q;
        tga_d        = tga_q;
        tgc_d        = tgc_q;
        tgd_d        = tgd_q;
        resp_valid_d = 1'b0;
        resp_dat_d   = resp_dat_q;
        resp_tgd_d   = resp_tgd_q;
        resp_err_d   = resp_err_q;
        resp_code_d  = resp_code_q;
        retry_d      = retry_q;
        tmo_d        = tmo_q;
        gap_d        = gap_q;
        done_s       = 1'b0;
        code_s       = 2'b00;

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid_i && req_ready_q) begin
                    state_d     = ST_BUS;
                    req_ready_d = 1'b0;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    lock_d      = req_lock_i;
                    lock_req_d  = req_lock_i;
                    we_d        = req_we_i;
                    adr_d       = req_adr_i;
                    dat_d       = req_dat_i;
                    sel_d       = req_sel_i;
                    tga_d       = req_tga_i;
                    tgc_d       = req_tgc_i;
                    tgd_d       = req_tgd_i;
                    tmo_d       = {TW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                // err outranks rty, which outranks ack, when several arrive together
                if (err_i) begin
                    done_s = 1'b1;
                    code_s = 2'b01;
                end else if (rty_i) begin
                    if (retry_q < RETRY_MAX_C) begin
                        retry_d = retry_q + RW'(1);
                        gap_d   = {GW{1'b0}};
                        state_d = ST_GAP;
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        lock_d  = 1'b0;
                    end else begin
                        done_s = 1'b1;
                        code_s = 2'b10;
                    end
                end else if (ack_i) begin
                    done_s = 1'b1;
                    code_s = 2'b00;
                    if (!we_q) begin
                        resp_dat_d = dat_i;
                        resp_tgd_d = tgd_i;
                    end else begin
                        resp_dat_d = resp_dat_q;
                        resp_tgd_d = resp_tgd_q;
                    end
                end else if (tmo_q == TMO_LAST_C) begin
                    done_s = 1'b1;
                    code_s = 2'b11;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST_C) begin
                    state_d = ST_BUS;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    lock_d  = lock_req_q;
                    tmo_d   = {TW{1'b0}};
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                retry_d     = {RW{1'b0}};
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                cyc_d       = 1'b0;
                stb_d       = 1'b0;
                lock_d      = 1'b0;
                retry_d     = {RW{1'b0}};
            end
        endcase

        if (done_s) begin
            state_d      = ST_RESP;
            cyc_d        = 1'b0;
            stb_d        = 1'b0;
            lock_d       = 1'b0;
            resp_valid_d = 1'b1;
            resp_code_d  = code_s;
            resp_err_d   = (code_s != 2'b00);
        end else begin
            resp_valid_d = 1'b0;
        end
    end

    // State and registered-output flops; reset also kills any cycle in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            lock_q       <= 1'b0;
            lock_req_q   <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= {ADDR_WIDTH{1'b0}};
            dat_q        <= {DATA_WIDTH{1'b0}};
            sel_q        <= {SEL_WIDTH{1'b0}};
            tga_q        <= {TGA_WIDTH{1'b0}};
            tgc_q        <= {TGC_WIDTH{1'b0}};
            tgd_q        <= {TGDO_WIDTH{1'b0}};
            resp_valid_q <= 1'b0;
            resp_dat_q   <= {DATA_WIDTH{1'b0}};
            resp_tgd_q   <= {TGDI_WIDTH{1'b0}};
            resp_err_q   <= 1'b0;
            resp_code_q  <= 2'b00;
            retry_q      <= {RW{1'b0}};
            tmo_q        <= {TW{1'b0}};
            gap_q        <= {GW{1'b0}};
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            lock_q       <= lock_d;
            lock_req_q   <= lock_req_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            sel_q        <= sel_d;
            tga_q        <= tga_d;
            tgc_q        <= tgc_d;
            tgd_q        <= tgd_d;
            resp_valid_q <= resp_valid_d;
            resp_dat_q   <= resp_dat_d;
            resp_tgd_q   <= resp_tgd_d;
            resp_err_q   <= resp_err_d;
            resp_code_q  <= resp_code_d;
            retry_q      <= retry_d;
            tmo_q        <= tmo_d;
            gap_q        <= gap_d;
        end
    end

    assign req_ready_o  = req_ready_q;
    assign cyc_o        = cyc_q;
    assign stb_o        = stb_q;
    assign lock_o       = lock_q;
    assign we_o         = we_q;
    assign adr_o        = adr_q;
    assign dat_o        = dat_q;
    assign sel_o        = sel_q;
    assign tga_o        = tga_q;
    assign tgc_o        = tgc_q;
    assign tgd_o        = tgd_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_dat_o   = resp_dat_q;
    assign resp_tgd_o   = resp_tgd_q;
    assign resp_err_o   = resp_err_q;
    assign resp_code_o  = resp_code_q;

endmodule

// File: tb/tb_wb_master_port.sv
// Directed bench for wb_master_port: each task plays the responder for one scenario
// and compares the master's bus and response outputs against hand-derived values.
module tb_wb_master_port;

    logic        clk;
    logic        rst_i;
    logic        req_valid_i, req_ready_o, req_we_i, req_lock_i;
    logic [31:0] req_adr_i, req_dat_i;
    logic [3:0]  req_sel_i;
    logic [0:0]  req_tga_i, req_tgc_i, req_tgd_i;
    logic        resp_valid_o, resp_err_o;
    logic [31:0] resp_dat_o;
    logic [0:0]  resp_tgd_o;
    logic [1:0]  resp_code_o;
    logic [31:0] adr_o, dat_o, dat_i;
    logic        we_o, cyc_o, stb_o, lock_o, ack_i, err_i, rty_i;
    logic [3:0]  sel_o;
    logic [0:0]  tga_o, tgc_o, tgd_o, tgd_i;

    int checks = 0;
    int errors = 0;

    wb_master_port dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_adr_i(req_adr_i), .req_dat_i(req_dat_i), .req_sel_i(req_sel_i),
        .req_lock_i(req_lock_i), .req_tga_i(req_tga_i), .req_tgc_i(req_tgc_i),
        .req_tgd_i(req_tgd_i), .resp_valid_o(resp_valid_o), .resp_dat_o(resp_dat_o),
        .resp_tgd_o(resp_tgd_o), .resp_err_o(resp_err_o), .resp_code_o(resp_code_o),
        .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o), .sel_o(sel_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .lock_o(lock_o), .ack_i(ack_i), .err_i(err_i),
        .rty_i(rty_i), .tga_o(tga_o), .tgc_o(tgc_o), .tgd_o(tgd_o), .tgd_i(tgd_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request; it is taken on the next edge because the master is idle.
    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic lock);
        req_we_i = we; req_adr_i = adr; req_dat_i = dat; req_sel_i = sel; req_lock_i = lock;
        req_valid_i = 1'b1;
        step();
        req_valid_i = 1'b0;
    endtask

    // Responder: rty on the first n_rty strobes (all of them if negative), then ack.
    task automatic run_bus(input int n_rty, output int attempts, output int bad_gaps,
                           output logic seen);
        int low;
        attempts = 0; bad_gaps = 0; low = 0; seen = 1'b0;
        for (int c = 0; c < 80 && !seen; c++) begin
            if (resp_valid_o) begin
                seen = 1'b1;
            end else begin
                if (stb_o) begin
                    if (attempts > 0 && low != 2) bad_gaps++;
                    low = 0;
                    attempts++;
                    rty_i = (n_rty < 0) || (attempts <= n_rty);
                    ack_i = !rty_i;
                    dat_i = 32'hCAFE0000 | 32'(attempts);
                end else begin
                    rty_i = 1'b0; ack_i = 1'b0; low++;
                end
                step();
            end
        end
        rty_i = 1'b0; ack_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (2) step();
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready_o); end
        checks++; if ({cyc_o, stb_o, lock_o, we_o} !== 4'b0000) begin errors++; $display("FAIL reset_bus got %b want 0000", {cyc_o, stb_o, lock_o, we_o}); end
        checks++; if ({resp_valid_o, resp_err_o, resp_code_o} !== 4'b0000) begin errors++; $display("FAIL reset_resp got %b want 0000", {resp_valid_o, resp_err_o, resp_code_o}); end
        checks++; if (adr_o !== 32'h0) begin errors++; $display("FAIL reset_adr got %h want 0", adr_o); end
        rst_i = 1'b1;
        step();
    endtask

    task automatic test_read();
        tgd_i = 1'b1;
        issue(1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b0);
        checks++; if ({cyc_o, stb_o, we_o, req_ready_o} !== 4'b1100) begin errors++; $display("FAIL read_bus got %b want 1100", {cyc_o, stb_o, we_o, req_ready_o}); end
        checks++; if (adr_o !== 32'h10 || sel_o !== 4'hF) begin errors++; $display("FAIL read_adr got %h/%h want 10/f", adr_o, sel_o); end
        ack_i = 1'b1; dat_i = 32'hDEADBEEF;
        step();
        ack_i = 1'b0; tgd_i = 1'b0;
        checks++; if (cyc_o !== 1'b0 || resp_valid_o !== 1'b1) begin errors++; $display("FAIL read_term got cyc %b rv %b want 0 1", cyc_o, resp_valid_o); end
        checks++; if (resp_dat_o !== 32'hDEADBEEF || resp_tgd_o !== 1'b1) begin errors++; $display("FAIL read_data got %h/%b want deadbeef/1", resp_dat_o, resp_tgd_o); end
        checks++; if (resp_code_o !== 2'b00 || resp_err_o !== 1'b0) begin errors++; $display("FAIL read_code got %b/%b want 00/0", resp_code_o, resp_err_o); end
        step();
        checks++; if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin errors++; $display("FAIL read_idle got rv %b rdy %b want 0 1", resp_valid_o, req_ready_o); end
    endtask

    task automatic test_write();
        int bad = 0;
        issue(1'b1, 32'h20, 32'h12345678, 4'h3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if ({cyc_o, stb_o, we_o, lock_o} !== 4'b1111 || adr_o !== 32'h20 ||
                dat_o !== 32'h12345678 || sel_o !== 4'h3 || resp_valid_o !== 1'b0) bad++;
            if (i == 3) ack_i = 1'b1;
            step();
        end
        ack_i = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL write_stable got %0d bad cycles want 0", bad); end
        checks++; if ({cyc_o, lock_o, resp_valid_o} !== 3'b001) begin errors++; $display("FAIL write_term got %b want 001", {cyc_o, lock_o, resp_valid_o}); end
        checks++; if (resp_code_o !== 2'b00 || resp_err_o !== 1'b0) begin errors++; $display("FAIL write_code got %b/%b want 00/0", resp_code_o, resp_err_o); end
        checks++; if (resp_dat_o !== 32'hDEADBEEF) begin errors++; $display("FAIL write_holds_dat got %h want deadbeef", resp_dat_o); end
        step();
    endtask

    task automatic test_retry();
        int attempts, bad_gaps;
        logic seen;
        issue(1'b0, 32'h30, 32'h0, 4'hF, 1'b0);
        run_bus(2, attempts, bad_gaps, seen);
        checks++; if (seen !== 1'b1 || attempts !== 3) begin errors++; $display("FAIL retry_attempts got %0d seen %b want 3 1", attempts, seen); end
        checks++; if (bad_gaps !== 0) begin errors++; $display("FAIL retry_gap got %0d bad gaps want 0", bad_gaps); end
        checks++; if (resp_code_o !== 2'b00 || resp_dat_o !== 32'hCAFE0003) begin errors++; $display("FAIL retry_resp got %b/%h want 00/cafe0003", resp_code_o, resp_dat_o); end
        step();
    endtask

    task automatic test_rty_exhaust();
        int attempts, bad_gaps;
        logic seen;
        issue(1'b0, 32'h40, 32'h0, 4'hF, 1'b0);
        run_bus(-1, attempts, bad_gaps, seen);
        checks++; if (seen !== 1'b1 || attempts !== 4) begin errors++; $display("FAIL exhaust_attempts got %0d seen %b want 4 1", attempts, seen); end
        checks++; if (resp_code_o !== 2'b10 || resp_err_o !== 1'b1) begin errors++; $display("FAIL exhaust_code got %b/%b want 10/1", resp_code_o, resp_err_o); end
        checks++; if (resp_dat_o !== 32'hCAFE0003) begin errors++; $display("FAIL exhaust_dat got %h want cafe0003", resp_dat_o); end
        step();
    endtask

    task automatic test_timeout();
        int n = 0;
        issue(1'b0, 32'h50, 32'h0, 4'hF, 1'b0);
        while (cyc_o && n < 400) begin
            n++;
            step();
        end
        checks++; if (n !== 255) begin errors++; $display("FAIL timeout_len got %0d want 255", n); end
        checks++; if (resp_valid_o !== 1'b1 || resp_code_o !== 2'b11 || resp_err_o !== 1'b1) begin errors++; $display("FAIL timeout_code got %b/%b/%b want 1/11/1", resp_valid_o, resp_code_o, resp_err_o); end
        step();
    endtask

    task automatic test_err_ack();
        issue(1'b0, 32'h60, 32'h0, 4'hF, 1'b0);
        err_i = 1'b1; ack_i = 1'b1; dat_i = 32'h0BAD0BAD;
        step();
        err_i = 1'b0; ack_i = 1'b0;
        checks++; if (resp_valid_o !== 1'b1 || resp_code_o !== 2'b01 || resp_err_o !== 1'b1) begin errors++; $display("FAIL errack_code got %b/%b/%b want 1/01/1", resp_valid_o, resp_code_o, resp_err_o); end
        checks++; if (resp_dat_o !== 32'hCAFE0003) begin errors++; $display("FAIL errack_dat got %h want cafe0003", resp_dat_o); end
        step();
    endtask

    task automatic test_idle_ignore();
        ack_i = 1'b1; err_i = 1'b1;
        step();
        step();
        ack_i = 1'b0; err_i = 1'b0;
        checks++; if (resp_valid_o !== 1'b0 || cyc_o !== 1'b0 || req_ready_o !== 1'b1) begin errors++; $display("FAIL idle_ignore got rv %b cyc %b rdy %b want 0 0 1", resp_valid_o, cyc_o, req_ready_o); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        issue(1'b0, 32'h70, 32'h0, 4'hF, 1'b0);
        step();
        #2 rst_i = 1'b0;
        #1;
        checks++; if (cyc_o !== 1'b0 || stb_o !== 1'b0) begin errors++; $display("FAIL rst_async got cyc %b stb %b want 0 0", cyc_o, stb_o); end
        for (int i = 0; i < 3; i++) begin
            if (resp_valid_o) pulses++;
            step();
        end
        rst_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (resp_valid_o) pulses++;
            step();
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_no_resp got %0d pulses want 0", pulses); end
        issue(1'b0, 32'h80, 32'h0, 4'hF, 1'b0);
        ack_i = 1'b1; dat_i = 32'h55AA55AA;
        step();
        ack_i = 1'b0;
        checks++; if (resp_valid_o !== 1'b1 || resp_code_o !== 2'b00 || resp_dat_o !== 32'h55AA55AA) begin errors++; $display("FAIL rst_recover got %b/%b/%h want 1/00/55aa55aa", resp_valid_o, resp_code_o, resp_dat_o); end
        step();
    endtask

    initial begin
        rst_i = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_lock_i = 1'b0;
        req_adr_i = 32'h0; req_dat_i = 32'h0; req_sel_i = 4'h0;
        req_tga_i = 1'b0; req_tgc_i = 1'b0; req_tgd_i = 1'b0;
        dat_i = 32'h0; tgd_i = 1'b0; ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_retry();
        test_rty_exhaust();
        test_timeout();
        test_err_ack();
        test_idle_ignore();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
